// File: rtl/mem_responder.sv
// Unified instruction/data memory with req/ready handshake, WAIT_CYCLES wait states
// and a one-cycle RspValid pulse. Define MEM_ERR_CHECK_EN to reject misaligned/out-of-range accesses.
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Req,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  output logic                  ReqReady,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspRData,
  output logic                  RspErr,
  output logic                  Busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  addr_err;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

`ifdef MEM_ERR_CHECK_EN
  assign addr_err = (|ReqAddr[1:0]) | (|ReqAddr[ADDR_WIDTH-1:DEPTH_LOG2+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ReqAddr[ADDR_WIDTH-1:DEPTH_LOG2+2], ReqAddr[1:0]};
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          write_d = ReqWrite;
          idx_d   = ReqAddr[DEPTH_LOG2+1:2];
          wdata_d = ReqWData;
          err_d   = addr_err;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // Rejected accesses and stores leave the read register untouched
        rsp_err_d = err_q;
        if (!err_q && !write_q) rdata_d = mem[idx_q];
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we = (state_q == S_ACCESS) && write_q && !err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // The array keeps its contents across reset; only a reset-free ACCESS cycle writes it
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[idx_q] <= wdata_q;
  end

  assign ReqReady = (state_q == S_IDLE) & rst;
  assign Busy     = (state_q != S_IDLE);
  assign RspValid = rsp_valid_q;
  assign RspRData = rdata_q;
  assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with 2 wait states, one with none.
// Expectations follow MEM_ERR_CHECK_EN when the bench is built with it.
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req2 = 1'b0, req_write2 = 1'b0;
  logic [31:0] req_addr2 = '0, req_wdata2 = '0;
  logic        ready2, rsp_valid2, rsp_err2, busy2;
  logic [31:0] rsp_rdata2;

  logic        req0 = 1'b0, req_write0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic        ready0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q2[$];
  exp_t q0[$];
  exp_t m2, m0;
  logic [31:0] model2 [0:255];
  logic [31:0] last_rd2 = '0;

  mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .Req(req2), .ReqWrite(req_write2), .ReqAddr(req_addr2),
    .ReqWData(req_wdata2), .ReqReady(ready2), .RspValid(rsp_valid2), .RspRData(rsp_rdata2),
    .RspErr(rsp_err2), .Busy(busy2)
  );

  mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .Req(req0), .ReqWrite(req_write0), .ReqAddr(req_addr0),
    .ReqWData(req_wdata0), .ReqReady(ready0), .RspValid(rsp_valid0), .RspRData(rsp_rdata0),
    .RspErr(rsp_err0), .Busy(busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every response must match the oldest outstanding expectation, including its cycle
  always @(negedge clk) begin
    if (rsp_valid2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL rsp2_unexpected: RspValid=1 at cycle %0d, required no response", cyc);
      end else begin
        m2 = q2.pop_front();
        if (cyc !== m2.due) begin
          errors++;
          $display("FAIL rsp2_latency: got cycle %0d, required %0d", cyc, m2.due);
        end
        checks++;
        if (rsp_err2 !== m2.err) begin
          errors++;
          $display("FAIL rsp2_err: got %b, required %b", rsp_err2, m2.err);
        end
        checks++;
        if (rsp_rdata2 !== m2.rdata) begin
          errors++;
          $display("FAIL rsp2_rdata: got %h, required %h", rsp_rdata2, m2.rdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rsp0_unexpected: RspValid=1 at cycle %0d, required no response", cyc);
      end else begin
        m0 = q0.pop_front();
        if (cyc !== m0.due) begin
          errors++;
          $display("FAIL rsp0_latency: got cycle %0d, required %0d", cyc, m0.due);
        end
        checks++;
        if (rsp_err0 !== m0.err) begin
          errors++;
          $display("FAIL rsp0_err: got %b, required %b", rsp_err0, m0.err);
        end
        checks++;
        if (rsp_rdata0 !== m0.rdata) begin
          errors++;
          $display("FAIL rsp0_rdata: got %h, required %h", rsp_rdata0, m0.rdata);
        end
      end
    end
  end

  // Issues one request to the 2-wait-state instance and queues its expected response
  task automatic access2(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    int a;
    exp_t e;
    logic [7:0] idx;
    logic err;
    @(negedge clk);
    req2 = 1'b1; req_write2 = wr; req_addr2 = addr; req_wdata2 = wd;
    n = 0;
    while (ready2 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept2_timeout: ReqReady=%b, required 1 within 50 cycles", ready2);
      req2 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a = cyc;
    idx = addr[9:2];
`ifdef MEM_ERR_CHECK_EN
    err = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
`else
    err = 1'b0;
`endif
    if (!err) begin
      if (wr) model2[idx] = wd;
      else last_rd2 = model2[idx];
    end
    e.rdata = last_rd2;
    e.err   = err;
    e.due   = a + 4;
    q2.push_back(e);
    @(negedge clk);
    req2 = 1'b0;
  endtask

  task automatic drain2();
    int n = 0;
    while (q2.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL drain2_timeout: %0d responses outstanding, required 0", q2.size());
      q2.delete();
    end
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL drain0_timeout: %0d responses outstanding, required 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req2 = 1'b1; req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 3;
      if (ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready2); end
      if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", rsp_valid2); end
      if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy2); end
    end
    rst = 1'b1; req2 = 1'b0; req0 = 1'b0;
    @(negedge clk);
    checks += 3;
    if (ready2 !== 1'b1) begin errors++; $display("FAIL release_ready2: got %b, required 1", ready2); end
    if (ready0 !== 1'b1) begin errors++; $display("FAIL release_ready0: got %b, required 1", ready0); end
    if (rsp_rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rsp_rdata2); end
  endtask

  task automatic test_prefill();
    access2(1'b1, 32'h00, 32'h0000_0A00); drain2();
    access2(1'b1, 32'h08, 32'h8888_0008); drain2();
    access2(1'b1, 32'h20, 32'h0000_2020); drain2();
    access2(1'b1, 32'h30, 32'hA5A5_0030); drain2();
  endtask

  task automatic test_store_read();
    access2(1'b1, 32'h10, 32'hDEAD_BEEF);
    checks += 2;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL inflight_busy: got %b, required 1", busy2); end
    if (ready2 !== 1'b0) begin errors++; $display("FAIL inflight_ready: got %b, required 0", ready2); end
    drain2();
    access2(1'b0, 32'h10, 32'h0);
    drain2();
    checks++;
    if (rsp_rdata2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_back: got %h, required deadbeef", rsp_rdata2);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int a;
    exp_t e;
    @(negedge clk);
    req0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h0; req_wdata0 = 32'hC0DE_0000;
    n = 0;
    while (ready0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; a = cyc;
    e.rdata = 32'h0; e.err = 1'b0; e.due = a + 2;
    q0.push_back(e);
    @(negedge clk); req0 = 1'b0;
    drain0();
    @(negedge clk);
    req0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h0;
    @(posedge clk); #1; a = cyc;
    e.rdata = 32'hC0DE_0000; e.err = 1'b0; e.due = a + 2;
    q0.push_back(e);
    e.due = a + 5;
    q0.push_back(e);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy_first: got %b, required 1", busy0); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_rsp: got %b, required 1", ready0); end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy got %b, required 1", busy0); end
    req0 = 1'b0;
    drain0();
  endtask

  task automatic test_ignore_busy();
    access2(1'b0, 32'h30, 32'h0);
    @(negedge clk);
    req2 = 1'b1; req_write2 = 1'b1; req_addr2 = 32'h20; req_wdata2 = 32'hBAD0_BAD0;
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b, required 1", busy2); end
    @(negedge clk);
    req2 = 1'b0;
    drain2();
    checks++;
    if (rsp_rdata2 !== 32'hA5A5_0030) begin
      errors++; $display("FAIL ignore_data: got %h, required a5a50030", rsp_rdata2);
    end
    access2(1'b0, 32'h20, 32'h0);
    drain2();
  endtask

  task automatic test_addr_err();
    access2(1'b1, 32'h13, 32'h1111_1111); drain2();
    access2(1'b0, 32'h400, 32'h0); drain2();
    access2(1'b0, 32'h10, 32'h0); drain2();
    checks++;
`ifdef MEM_ERR_CHECK_EN
    if (rsp_rdata2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL err_no_write: got %h, required deadbeef", rsp_rdata2);
    end
`else
    if (rsp_rdata2 !== 32'h1111_1111) begin
      errors++; $display("FAIL trunc_write: got %h, required 11111111", rsp_rdata2);
    end
`endif
  endtask

  task automatic test_reset_inflight();
    int n;
    int seen;
    @(negedge clk);
    req2 = 1'b1; req_write2 = 1'b1; req_addr2 = 32'h08; req_wdata2 = 32'h1234_5678;
    n = 0;
    while (ready2 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b, required 1", busy2); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ready2 !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b, required 0", ready2); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b, required 0", busy2); end
    rst = 1'b1;
    last_rd2 = 32'h0;
    checks++;
    if (rsp_rdata2 !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h, required 0", rsp_rdata2); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid2 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp: got %0d responses, required 0", seen); end
    access2(1'b0, 32'h08, 32'h0);
    drain2();
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_store_read();
    test_back_to_back();
    test_ignore_busy();
    test_addr_err();
    test_reset_inflight();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t, required completion before 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
